// File: rtl/box_slave_pkg.sv
// Shared widths, response codes, FSM state type and the slot payload for the box write responder.
package box_slave_pkg;

  localparam int unsigned PDATA_WIDTH   = 32;
  localparam int unsigned PSTRB_WIDTH   = PDATA_WIDTH / 8;
  localparam int unsigned PLENGTH_WIDTH = 8;
  localparam int unsigned ID_WIDTH      = 4;
  localparam int unsigned ADDR_WIDTH    = 32;
  localparam int unsigned USER_WIDTH    = 4;
  localparam int unsigned MAX_BEATS     = 16;
  localparam int unsigned CNT_WIDTH     = PLENGTH_WIDTH + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, DELIVER, RESP} box_slv_state_t;

  // One complete write burst as handed to the special memory.
  typedef struct packed {
    logic [ID_WIDTH-1:0]                id;
    logic [ADDR_WIDTH-1:0]              addr;
    logic [PLENGTH_WIDTH-1:0]           len;
    logic [2:0]                         size;
    logic [1:0]                         burst;
    logic [USER_WIDTH-1:0]              user;
    logic [MAX_BEATS*PSTRB_WIDTH-1:0]   strb;
    logic [MAX_BEATS*PDATA_WIDTH-1:0]   data;
  } spec_slot;

endpackage

// File: rtl/axi_if.sv
// AXI write address/data channels between a box master and box_slave.
interface axi_if;
  import box_slave_pkg::*;

  logic                     awvalid;
  logic                     awready;
  logic [ID_WIDTH-1:0]      awid;
  logic [ADDR_WIDTH-1:0]    awaddr;
  logic [PLENGTH_WIDTH-1:0] awlen;
  logic [2:0]               awsize;
  logic [1:0]               awburst;
  logic [USER_WIDTH-1:0]    awuser;

  logic                     wvalid;
  logic                     wready;
  logic [ID_WIDTH-1:0]      wid;
  logic [PDATA_WIDTH-1:0]   wdata;
  logic [PSTRB_WIDTH-1:0]   wstrb;
  logic                     wlast;

  modport slave_add (input awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
                     output awready);
  modport slave_data (input wvalid, wid, wdata, wstrb, wlast,
                      output wready);

endinterface

// File: rtl/box_slave_slot_packer.sv
// Beat counter and data/strb packing for one burst; flags length/id/overflow errors.
module slot_packer
  import box_slave_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [PLENGTH_WIDTH-1:0]         start_len,
  input  logic [PLENGTH_WIDTH-1:0]         cur_len,
  input  logic [ID_WIDTH-1:0]              cur_id,
  input  logic                             beat,
  input  logic [ID_WIDTH-1:0]              wid,
  input  logic [PDATA_WIDTH-1:0]           wdata,
  input  logic [PSTRB_WIDTH-1:0]           wstrb,
  input  logic                             wlast,
  output logic [MAX_BEATS*PDATA_WIDTH-1:0] data,
  output logic [MAX_BEATS*PSTRB_WIDTH-1:0] strb,
  output logic                             err,
  output logic                             done_c
);

  logic [CNT_WIDTH-1:0] beat_cnt;
  logic [CNT_WIDTH-1:0] len_ext_c;
  logic                 in_range_c;
  logic                 within_len_c;
  logic                 store_c;
  logic                 beat_err_c;

  // Beats past the slot capacity or past awlen (late last) are dropped.
  always_comb begin
    len_ext_c    = {1'b0, cur_len};
    in_range_c   = (beat_cnt < CNT_WIDTH'(MAX_BEATS));
    within_len_c = (beat_cnt <= len_ext_c);
    store_c      = beat & in_range_c & within_len_c;
    beat_err_c   = beat & ((wid != cur_id) | ~in_range_c |
                           (wlast & (beat_cnt < len_ext_c)) |
                           (~wlast & (beat_cnt >= len_ext_c)));
    done_c       = beat & wlast;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      data     <= '0;
      strb     <= '0;
      err      <= 1'b0;
    end else if (start) begin
      beat_cnt <= '0;
      data     <= '0;
      strb     <= '0;
      err      <= (start_len >= PLENGTH_WIDTH'(MAX_BEATS));
    end else if (beat) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      if (beat_err_c) err <= 1'b1;
      for (int unsigned i = 0; i < MAX_BEATS; i++) begin
        if (store_c && (beat_cnt == CNT_WIDTH'(i))) begin
          data[i*PDATA_WIDTH +: PDATA_WIDTH] <= wdata;
          strb[i*PSTRB_WIDTH +: PSTRB_WIDTH] <= wstrb;
        end
      end
    end
  end

endmodule

// File: rtl/box_slave.sv
// Box write responder: takes one AW + W burst, delivers it as a spec_slot, then returns B.
module box_slave
  import box_slave_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  axi_if.slave_add            s_add,
  axi_if.slave_data           s_data,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                slot_valid,
  input  logic                slot_ready,
  output spec_slot            out_slot
);

  box_slv_state_t state_q, state_nxt;

  logic                     awready_q, awready_nxt;
  logic                     wready_q, wready_nxt;
  logic                     slot_valid_nxt;
  logic                     bvalid_nxt;
  logic [ID_WIDTH-1:0]      bid_nxt;
  logic [1:0]               bresp_nxt;

  logic [ID_WIDTH-1:0]      hdr_id;
  logic [ADDR_WIDTH-1:0]    hdr_addr;
  logic [PLENGTH_WIDTH-1:0] hdr_len;
  logic [2:0]               hdr_size;
  logic [1:0]               hdr_burst;
  logic [USER_WIDTH-1:0]    hdr_user;

  logic [MAX_BEATS*PDATA_WIDTH-1:0] pk_data;
  logic [MAX_BEATS*PSTRB_WIDTH-1:0] pk_strb;
  logic                             pk_err;
  logic                             pk_done_c;

  logic aw_fire_c;
  logic w_beat_c;

  assign s_add.awready = awready_q;
  assign s_data.wready = wready_q;
  assign aw_fire_c     = s_add.awvalid & awready_q;
  assign w_beat_c      = s_data.wvalid & wready_q;

  slot_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (aw_fire_c),
    .start_len (s_add.awlen),
    .cur_len   (hdr_len),
    .cur_id    (hdr_id),
    .beat      (w_beat_c),
    .wid       (s_data.wid),
    .wdata     (s_data.wdata),
    .wstrb     (s_data.wstrb),
    .wlast     (s_data.wlast),
    .data      (pk_data),
    .strb      (pk_strb),
    .err       (pk_err),
    .done_c    (pk_done_c)
  );

  // Burst header captured on the AW handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_id    <= '0;
      hdr_addr  <= '0;
      hdr_len   <= '0;
      hdr_size  <= '0;
      hdr_burst <= '0;
      hdr_user  <= '0;
    end else if (aw_fire_c) begin
      hdr_id    <= s_add.awid;
      hdr_addr  <= s_add.awaddr;
      hdr_len   <= s_add.awlen;
      hdr_size  <= s_add.awsize;
      hdr_burst <= s_add.awburst;
      hdr_user  <= s_add.awuser;
    end
  end

  always_comb begin
    out_slot       = '0;
    out_slot.id    = hdr_id;
    out_slot.addr  = hdr_addr;
    out_slot.len   = hdr_len;
    out_slot.size  = hdr_size;
    out_slot.burst = hdr_burst;
    out_slot.user  = hdr_user;
    out_slot.strb  = pk_strb;
    out_slot.data  = pk_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      slot_valid <= 1'b0;
      bvalid     <= 1'b0;
      bid        <= '0;
      bresp      <= '0;
    end else begin
      state_q    <= state_nxt;
      awready_q  <= awready_nxt;
      wready_q   <= wready_nxt;
      slot_valid <= slot_valid_nxt;
      bvalid     <= bvalid_nxt;
      bid        <= bid_nxt;
      bresp      <= bresp_nxt;
    end
  end

  // Next state and next values of the registered handshake outputs.
  always_comb begin
    state_nxt      = state_q;
    awready_nxt    = awready_q;
    wready_nxt     = wready_q;
    slot_valid_nxt = slot_valid;
    bvalid_nxt     = bvalid;
    bid_nxt        = bid;
    bresp_nxt      = bresp;
    case (state_q)
      IDLE: begin
        awready_nxt = 1'b1;
        if (aw_fire_c) begin
          awready_nxt = 1'b0;
          wready_nxt  = 1'b1;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (pk_done_c) begin
          wready_nxt     = 1'b0;
          slot_valid_nxt = 1'b1;
          state_nxt      = DELIVER;
        end
      end
      DELIVER: begin
        if (slot_valid && slot_ready) begin
          slot_valid_nxt = 1'b0;
          bvalid_nxt     = 1'b1;
          bid_nxt        = hdr_id;
          bresp_nxt      = pk_err ? RESP_SLVERR : RESP_OKAY;
          state_nxt      = RESP;
        end
      end
      RESP: begin
        if (bvalid && bready) begin
          bvalid_nxt  = 1'b0;
          awready_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
